uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Sits directly downstream of the UART receiver. Consumes its one-cycle byte strobes.
//  Assembles framed commands: 0xA5, CMD, LEN, LEN payload bytes, CHK.
//  CHK = XOR of CMD, LEN and every payload byte.
//  Good frames are presented with a valid/ready handshake; bad frames raise an error pulse.
// PARAMETERS
//  MAX_LEN       16    largest accepted LEN value (1..2**ADDR_W)
//  ADDR_W        4     payload buffer address width
//  TIMEOUT_CLKS  8680  idle clocks allowed between bytes mid-frame (2 byte times, 115200 baud @ 50 MHz)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active-high
//  rx_data    in   8       received byte; meaningful only when rx_vld=1
//  rx_vld     in   1       one-cycle byte strobe from the UART receiver
//  frame_vld  out  1       complete, checksum-good frame held
//  frame_rdy  in   1       consumer accepts the frame
//  frame_cmd  out  8       CMD byte of the held frame
//  frame_len  out  ADDR_W+1  LEN of the held frame
//  rd_addr    in   ADDR_W  payload read address
//  rd_data    out  8       payload[rd_addr], registered
//  err        out  1       one-cycle error pulse
//  err_code   out  2       0=overrun, 1=LEN>MAX_LEN, 2=bad checksum, 3=timeout; valid with err
// BEHAVIOUR
//  Reset values
//   - Clock and reset are fixed: one clock; reset is asynchronous and active-high.
//   - While rst=1: state IDLE; frame_vld, frame_cmd, frame_len, err, err_code and rd_data all 0.
//   - Reset mid-frame discards any partial frame; the buffer contents are don't-care.
//  State machine (states IDLE, CMD, LEN, DATA, CHK, HOLD); transitions occur only on rx_vld unless noted
//   - IDLE: byte 0xA5 -> CMD. Any other byte is dropped silently.
//   - CMD: latch CMD and seed the running XOR with it -> LEN.
//   - LEN, value > MAX_LEN: err, code 1 -> IDLE.
//   - LEN = 0 -> CHK.
//   - LEN, otherwise: latch LEN, clear the write pointer -> DATA.
//   - DATA: write byte to buffer[wptr], XOR it into the checksum, wptr++. After the LEN-th byte -> CHK.
//   - CHK, byte == XOR: -> HOLD; frame_vld is set at the next clock edge.
//   - CHK, byte != XOR: err, code 2 -> IDLE.
//   - HOLD: frame_vld=1, and frame_cmd/frame_len/buffer stay stable until frame_vld&frame_rdy.
//     The cycle after the transfer, frame_vld=0 -> IDLE.
//   - HOLD, any rx_vld (including the handshake cycle): byte dropped, err code 0. Held frame is unaffected.
//  Timeout
//   - Applies in CMD, LEN, DATA and CHK only.
//   - The counter clears on rx_vld and increments on every other cycle.
//   - On reaching TIMEOUT_CLKS-1 with rx_vld=0: -> IDLE, err code 3.
//   - In IDLE and HOLD the counter is held at 0.
//  Timing
//   - err is registered: it pulses exactly 1 cycle, in the cycle after the offending byte or timeout.
//   - Simultaneous timeout expiry and rx_vld: the byte wins and the counter clears.
//  Payload read port
//   - rd_data = buffer[rd_addr] one clock after rd_addr is presented.
//   - Contents are defined only while frame_vld=1.
//   - Addresses >= frame_len return don't-care.
//  Widths
//   - Checksum is 8-bit XOR with no carry.
//   - frame_len is ADDR_W+1 bits so that LEN=2**ADDR_W can be represented.
// TESTING
//  1. Send A5 01 02 11 22 30 with frame_rdy=0.
//     -> frame_vld=1, cmd=01, len=2; rd_addr 0/1 -> 11/22; err never asserts.
//  2. Same frame with CHK=31.
//     -> err=1 for one cycle, code=2; frame_vld stays 0; a following good frame is accepted.
//  3. Send A5 01 11 (LEN=17, MAX_LEN=16).
//     -> err code 1 after the LEN byte. Then A5 03 00 03 -> frame_vld, len=0.
//  4. Send 00 FF A5 09, then stall for TIMEOUT_CLKS cycles.
//     -> the leading 00 FF are ignored; err code 3 asserts at the exact cycle; a new A5 frame parses normally.
//  5. Frame held with frame_rdy=0, then send byte 44.
//     -> err code 0; cmd, len and payload unchanged. Raise frame_rdy -> frame_vld drops next cycle.
//  6. Assert rst during DATA.
//     -> all outputs 0. The next complete frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Framed command parser fed by a UART receiver: A5, CMD, LEN, payload, XOR checksum.
// A good frame is held for a valid/ready consumer; malformed traffic raises a one-cycle err.
module uart_cmd_parser #(
   parameter int MAX_LEN      = 16,
   parameter int ADDR_W       = 4,
   parameter int TIMEOUT_CLKS = 8680
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_vld,
   output logic              frame_vld,
   input  logic              frame_rdy,
   output logic [7:0]        frame_cmd,
   output logic [ADDR_W:0]   frame_len,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int LW    = ADDR_W + 1;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int TW    = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_DATA,
      S_CHK,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     wptr_q, wptr_d;
   logic [7:0]        xor_q, xor_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              frame_vld_q, frame_vld_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic [7:0]        mem_q [DEPTH];
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              timed;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      wptr_d      = wptr_q;
      xor_d       = xor_q;
      tmo_d       = '0;
      frame_vld_d = frame_vld_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      wr_en       = 1'b0;
      wr_addr     = wptr_q[ADDR_W-1:0];
      rd_data_d   = mem_q[rd_addr];
      timed       = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

      if (timed && !rx_vld) tmo_d = tmo_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (rx_vld && rx_data == 8'hA5) state_d = S_CMD;
         end
         S_CMD: begin
            if (rx_vld) begin
               cmd_d   = rx_data;
               xor_d   = rx_data;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_vld) begin
               if ({1'b0, rx_data} > MAX_LEN_W) begin
                  err_d      = 1'b1;
                  err_code_d = 2'd1;
                  state_d    = S_IDLE;
               end else begin
                  len_d   = LW'(rx_data);
                  xor_d   = xor_q ^ rx_data;
                  wptr_d  = '0;
                  state_d = (rx_data == 8'h00) ? S_CHK : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_vld) begin
               wr_en  = 1'b1;
               xor_d  = xor_q ^ rx_data;
               wptr_d = wptr_q + 1'b1;
               if ((wptr_q + 1'b1) == len_q) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_vld) begin
               if (rx_data == xor_q) begin
                  frame_vld_d = 1'b1;
                  state_d     = S_HOLD;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'd2;
                  state_d    = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            // Bytes arriving while a frame is held are dropped, even on the handshake cycle.
            if (rx_vld) begin
               err_d      = 1'b1;
               err_code_d = 2'd0;
            end
            if (frame_rdy) begin
               frame_vld_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (timed && !rx_vld && tmo_q == TMO_LAST) begin
         tmo_d      = '0;
         err_d      = 1'b1;
         err_code_d = 2'd3;
         state_d    = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         wptr_q      <= '0;
         xor_q       <= '0;
         tmo_q       <= '0;
         frame_vld_q <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         wptr_q      <= wptr_d;
         xor_q       <= xor_d;
         tmo_q       <= tmo_d;
         frame_vld_q <= frame_vld_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         rd_data_q   <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= rx_data;
   end

   assign frame_vld = frame_vld_q;
   assign frame_cmd = cmd_q;
   assign frame_len = len_q;
   assign rd_data   = rd_data_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a table of framed byte sequences plus
// hand-written sequences for max length, timeout, overrun and mid-frame reset.
module tb_uart_cmd_parser;

   localparam int T = 8680;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_vld = 1'b0;
   logic       frame_vld;
   logic       frame_rdy = 1'b0;
   logic [7:0] frame_cmd;
   logic [4:0] frame_len;
   logic [3:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       err;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .MAX_LEN(16),
      .ADDR_W(4),
      .TIMEOUT_CLKS(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_vld(rx_vld),
      .frame_vld(frame_vld),
      .frame_rdy(frame_rdy),
      .frame_cmd(frame_cmd),
      .frame_len(frame_len),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .err(err),
      .err_code(err_code)
   );

   typedef struct {
      logic [63:0] b;      // first byte in bits 63:56
      int          n;
      logic        exp_vld;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [7:0]  exp_cmd;
      logic [4:0]  exp_len;
      logic [7:0]  p0;
      logic [7:0]  p1;
   } vec_t;

   vec_t tv [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_vld  = 1'b1;
      tick();
      rx_vld  = 1'b0;
   endtask

   task automatic read_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      tick();
      chk(nm, rd_data, exp);
   endtask

   task automatic ack_chk();
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      chk("vld_drop_after_ack", frame_vld, 1'b0);
   endtask

   task automatic run_vec(input vec_t v, input bit do_ack);
      for (int i = 0; i < v.n; i++) begin
         send_byte(v.b[63-8*i -: 8]);
         if (i < v.n - 1) chk("err_mid_frame", err, 1'b0);
      end
      chk("err_after_last", err, v.exp_err);
      if (v.exp_err) chk("err_code", err_code, v.exp_code);
      chk("frame_vld", frame_vld, v.exp_vld);
      if (v.exp_vld) begin
         chk("frame_cmd", frame_cmd, v.exp_cmd);
         chk("frame_len", frame_len, v.exp_len);
         if (v.exp_len >= 5'd1) read_chk("payload0", 4'd0, v.p0);
         if (v.exp_len >= 5'd2) read_chk("payload1", 4'd1, v.p1);
         chk("vld_still_held", frame_vld, 1'b1);
         if (do_ack) ack_chk();
      end else begin
         tick();
         chk("err_one_cycle", err, 1'b0);
         chk("vld_stays_low", frame_vld, 1'b0);
      end
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_vld"}, frame_vld, 1'b0);
      chk({nm, "_cmd"}, frame_cmd, 8'h00);
      chk({nm, "_len"}, frame_len, 5'd0);
      chk({nm, "_err"}, err, 1'b0);
      chk({nm, "_code"}, err_code, 2'd0);
      chk({nm, "_rd"}, rd_data, 8'h00);
   endtask

   initial begin
      logic [7:0] x;
      bit         early;

      tv[0] = '{64'hA5_01_02_11_22_30_00_00, 6, 1'b1, 1'b0, 2'd0, 8'h01, 5'd2, 8'h11, 8'h22};
      tv[1] = '{64'hA5_01_02_11_22_31_00_00, 6, 1'b0, 1'b1, 2'd2, 8'h00, 5'd0, 8'h00, 8'h00};
      tv[2] = '{64'hA5_01_02_11_22_30_00_00, 6, 1'b1, 1'b0, 2'd0, 8'h01, 5'd2, 8'h11, 8'h22};
      tv[3] = '{64'hA5_01_11_00_00_00_00_00, 3, 1'b0, 1'b1, 2'd1, 8'h00, 5'd0, 8'h00, 8'h00};
      tv[4] = '{64'hA5_03_00_03_00_00_00_00, 4, 1'b1, 1'b0, 2'd0, 8'h03, 5'd0, 8'h00, 8'h00};
      tv[5] = '{64'h00_FF_A5_07_01_5A_5C_00, 7, 1'b1, 1'b0, 2'd0, 8'h07, 5'd1, 8'h5A, 8'h00};
      tv[6] = '{64'hA5_A5_00_A5_00_00_00_00, 4, 1'b1, 1'b0, 2'd0, 8'hA5, 5'd0, 8'h00, 8'h00};
      tv[7] = '{64'hA5_02_02_80_01_81_00_00, 6, 1'b1, 1'b0, 2'd0, 8'h02, 5'd2, 8'h80, 8'h01};
      tv[8] = '{64'hA5_04_01_FF_FB_00_00_00, 5, 1'b0, 1'b1, 2'd2, 8'h00, 5'd0, 8'h00, 8'h00};
      tv[9] = '{64'hA5_00_FF_00_00_00_00_00, 3, 1'b0, 1'b1, 2'd1, 8'h00, 5'd0, 8'h00, 8'h00};

      // Reset values
      tick();
      tick();
      chk_zero_outputs("reset");
      rst = 1'b0;
      tick();

      for (int k = 0; k < 10; k++) run_vec(tv[k], 1'b1);

      // Largest accepted LEN: 16 bytes 00,11,..,FF
      send_byte(8'hA5);
      send_byte(8'h10);
      send_byte(8'h10);
      x = 8'h10 ^ 8'h10;
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i * 17));
         x = x ^ 8'(i * 17);
      end
      send_byte(x);
      chk("max_vld", frame_vld, 1'b1);
      chk("max_len", frame_len, 5'd16);
      chk("max_cmd", frame_cmd, 8'h10);
      read_chk("max_p0", 4'd0, 8'h00);
      read_chk("max_p7", 4'd7, 8'h77);
      read_chk("max_p15", 4'd15, 8'hFF);
      ack_chk();

      // Timeout: leading junk ignored, err 3 exactly T cycles after the last byte
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hA5);
      send_byte(8'h09);
      early = 1'b0;
      for (int i = 1; i < T; i++) begin
         tick();
         if (err) early = 1'b1;
      end
      chk("tmo_not_early", early, 1'b0);
      tick();
      chk("tmo_err", err, 1'b1);
      chk("tmo_code", err_code, 2'd3);
      tick();
      chk("tmo_err_one_cycle", err, 1'b0);
      run_vec(tv[0], 1'b1);

      // A byte on the expiry cycle wins over the timeout
      send_byte(8'hA5);
      early = 1'b0;
      for (int i = 1; i < T; i++) begin
         tick();
         if (err) early = 1'b1;
      end
      send_byte(8'h03);
      chk("tmo_race_no_err", err | early, 1'b0);
      send_byte(8'h00);
      send_byte(8'h03);
      chk("tmo_race_vld", frame_vld, 1'b1);
      chk("tmo_race_cmd", frame_cmd, 8'h03);
      ack_chk();

      // Overrun while holding a frame
      run_vec(tv[0], 1'b0);
      send_byte(8'h44);
      chk("ovr_err", err, 1'b1);
      chk("ovr_code", err_code, 2'd0);
      chk("ovr_vld", frame_vld, 1'b1);
      chk("ovr_cmd", frame_cmd, 8'h01);
      chk("ovr_len", frame_len, 5'd2);
      tick();
      chk("ovr_err_one_cycle", err, 1'b0);
      read_chk("ovr_p0", 4'd0, 8'h11);
      read_chk("ovr_p1", 4'd1, 8'h22);
      // Byte on the handshake cycle: still an overrun, transfer still completes
      frame_rdy = 1'b1;
      rx_data   = 8'h55;
      rx_vld    = 1'b1;
      tick();
      frame_rdy = 1'b0;
      rx_vld    = 1'b0;
      chk("ovr_hs_err", err, 1'b1);
      chk("ovr_hs_code", err_code, 2'd0);
      chk("ovr_hs_vld", frame_vld, 1'b0);
      run_vec(tv[7], 1'b1);

      // Asynchronous reset during DATA
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h11);
      #2 rst = 1'b1;
      #1;
      chk_zero_outputs("rst_mid");
      tick();
      rst = 1'b0;
      run_vec(tv[0], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
